grp_sampler: RTL
================

# grp_sampler

Parametrised successor to the logic-analyser sampler. It captures a `WIDTH`-bit probe bus at a programmable divided rate and packs only the enabled channel groups, contiguously and toward the LSB, into each sample word. Each captured word is presented with a one-cycle strobe to the downstream trigger/storage stage. It sits between the probe input pins and the trigger/memory path of the analyser core.

## Interface
- `WIDTH`, 32, probe channel count; must be a multiple of `GRP_W`
- `GRP_W`, 8, channels per group
- `DIV_W`, 24, divider register width
- `NGRP`, `WIDTH/GRP_W`, derived group count; not overridable
- `clk_i` input 1: system clock; all logic is on the rising edge
- `rst_i` input 1: reset, synchronous, active-high
- `en_i` input 1: run enable; when low, the counter is held cleared and no strobes are produced
- `fdiv_i` input `DIV_W`: divider value; sample period is `fdiv_i+1` cycles
- `set_div_i` input 1: load `fdiv_i` into the divider register
- `grp_en_i` input `NGRP`: group enable mask; bit g enables channels `[g*GRP_W +: GRP_W]`
- `data_i` input `WIDTH`: probe bus
- `smpls_o` output `WIDTH`: packed sample word
- `stb_o` output 1: one-cycle pulse marking a new `smpls_o`

## Operation
- Registers:
  - `div_q` (`DIV_W`)
  - `cnt_q` (`DIV_W`)
  - `smpls_o`
  - `stb_o`
- Reset values: all four registers are 0, and so are any synchroniser stages.
- Per-edge priority, highest first:
  1. `rst_i`: clear everything.
  2. `set_div_i`: `div_q<=fdiv_i`, `cnt_q<=0`, `stb_o<=0`. No capture on this edge, even if `en_i=1`.
  3. `en_i=0`: `cnt_q<=0`, `stb_o<=0`. `smpls_o` holds.
  4. `en_i=1` and `cnt_q==div_q`: capture, `cnt_q<=0`.
  5. `en_i=1` and `cnt_q!=div_q`: `cnt_q<=cnt_q+1`, `stb_o<=0`.
- Capture:
  - `smpls_o` is loaded with the packed word, and `stb_o<=1` if `grp_en_i` is nonzero.
  - If `grp_en_i==0`: `stb_o<=0` and `smpls_o` holds. The counter still restarts as normal.
- Packing:
  - Enabled groups are placed in ascending group index into consecutive `GRP_W` slots starting at bit 0.
  - Unused upper slots are 0.
  - `grp_en_i` is evaluated on the capture edge.
- Counter arithmetic: `cnt_q` never exceeds `div_q`, so no wrap occurs.
  - `div_q=0`: capture on every enabled edge.
  - `div_q=2^DIV_W-1`: period of `2^DIV_W` cycles.
- A change to `fdiv_i` without `set_div_i` has no effect.
- Deasserting `en_i` mid-period discards the partial count. A pulse already issued on `stb_o` is not retracted.

## Timing
- `stb_o` is always exactly one cycle wide.
- Consecutive strobes are spaced `div_q+1` cycles apart.
- First capture after `en_i` rises (with `cnt_q=0`): on the `(div_q+1)`-th rising edge with `en_i=1`.
- Latency: `data_i` sampled at edge N appears on `smpls_o`, with `stb_o=1`, in the cycle after edge N. That is 1 cycle, plus 2 if synchronisers are compiled in (see Configuration).
- `set_div_i` together with `en_i=1`: the next capture occurs `fdiv_i+1` edges after the load edge.
- `rst_i` mid-period: on the next cycle the outputs are 0 and `div_q=0`.

## Configuration
- `GRP_SAMPLER_SYNC_EN`
  - Defined: `data_i` passes through a two-flop synchroniser (reset to 0) before packing. Capture uses the synchronised value, so `data_i`→`smpls_o` latency is 3 cycles. Divider and strobe timing are unchanged.
  - Undefined: `data_i` is captured directly, with 1-cycle latency.

## Test plan
- Reset:
  - Stimulus: assert `rst_i` for 2 cycles with `en_i=1`, `data_i=32'hFFFF_FFFF`.
  - Required response: `smpls_o=0` and `stb_o=0` throughout. After release with `div_q=0`, the first `stb_o` comes 1 cycle later.
- Divider:
  - Stimulus: `set_div_i` with `fdiv_i=3`, `grp_en_i=4'hF`, `en_i=1`.
  - Required response: `stb_o` pulses every 4 cycles, and `smpls_o` equals `data_i` from the capture edge.
  - Stimulus: reload `fdiv_i=0`.
  - Required response: a strobe every cycle.
- Packing:
  - Stimulus: `data_i=32'hDDCC_BBAA` with `grp_en_i=4'b1010`.
  - Required response: `smpls_o=32'h0000_DDBB`.
  - Stimulus: `grp_en_i=4'b0100`.
  - Required response: `smpls_o=32'h0000_00CC`.
  - Stimulus: `grp_en_i=0`.
  - Required response: no `stb_o`, and `smpls_o` holds its previous value.
- Enable gating:
  - Stimulus: `fdiv_i=5`; drop `en_i` after 3 cycles, then restore it.
  - Required response: the next `stb_o` comes on the 6th enabled edge after restore.
- Simultaneous events:
  - Stimulus: `set_div_i=1` exactly on a capture edge.
  - Required response: no strobe on that edge, and the counter restarts from 0.
- Synchroniser (`GRP_SAMPLER_SYNC_EN` defined):
  - Stimulus: a one-cycle `data_i` change with `fdiv_i=0`.
  - Required response: the change appears on `smpls_o` 3 cycles after it is applied.

Source files
------------

// File: rtl/grp_sampler.sv
// Divided-rate probe sampler: captures enabled channel groups, packs them toward the LSB, and strobes each word.
// Optional `GRP_SAMPLER_SYNC_EN adds a two-flop input synchroniser (two extra cycles of data latency).
module grp_sampler #(
  parameter int WIDTH = 32,
  parameter int GRP_W = 8,
  parameter int DIV_W = 24,
  localparam int NGRP = WIDTH / GRP_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] fdiv_i,
  input  logic             set_div_i,
  input  logic [NGRP-1:0]  grp_en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] smpls_o,
  output logic             stb_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] smpls_q, smpls_d;
  logic             stb_q, stb_d;
  logic [WIDTH-1:0] cap_data;
  logic [WIDTH-1:0] packed_w;

`ifdef GRP_SAMPLER_SYNC_EN
  logic [WIDTH-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= data_i;
      sync2_q <= sync1_q;
    end
  end

  assign cap_data = sync2_q;
`else
  assign cap_data = data_i;
`endif

  // Enabled groups fill consecutive slots from bit 0; unused upper slots stay zero.
  always_comb begin
    int slot;
    packed_w = '0;
    slot     = 0;
    for (int g = 0; g < NGRP; g++) begin
      if (grp_en_i[g]) begin
        packed_w[slot*GRP_W +: GRP_W] = cap_data[g*GRP_W +: GRP_W];
        slot++;
      end
    end
  end

  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    smpls_d = smpls_q;
    stb_d   = 1'b0;
    if (set_div_i) begin
      div_d = fdiv_i;
      cnt_d = '0;
    end else if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q == div_q) begin
      // Period restarts even when no group is enabled; only the word/strobe are suppressed.
      cnt_d = '0;
      if (|grp_en_i) begin
        smpls_d = packed_w;
        stb_d   = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q   <= '0;
      cnt_q   <= '0;
      smpls_q <= '0;
      stb_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      smpls_q <= smpls_d;
      stb_q   <= stb_d;
    end
  end

  assign smpls_o = smpls_q;
  assign stb_o   = stb_q;

endmodule
